// File: rtl/gen_fifo_defines_pkg.sv
// Shared types and constants for the FIFO write-side stimulus generator.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package gen_fifo_defines_pkg;

    localparam int unsigned DEF_DATA_WIDTH = `DATA_WIDTH;
    localparam logic [31:0] LFSR32_POLY    = 32'h8020_0003;
    localparam logic [15:0] LFSR16_POLY    = 16'hB400;
    localparam logic [31:0] DEF_SEED       = 32'hACE1_2024;
    localparam logic [15:0] THR_SEED       = 16'hBEEF;

    typedef enum logic [1:0] {INCR, LFSR, WALK1, CONST} gen_mode_e;
    typedef enum logic [1:0] {IDLE, RUN, DONE} gen_state_e;

endpackage

// File: rtl/gen_fifo_lfsr.sv
// Right-shifting Galois LFSR with synchronous load and step enable; exposes the low OUT_W bits.
// Updates one cycle after load/step; load takes priority over step.
module gen_fifo_lfsr #(
    parameter int unsigned  W       = 32,
    parameter logic [W-1:0] POLY    = '1,
    parameter logic [W-1:0] RST_VAL = '1,
    parameter int unsigned  OUT_W   = W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [W-1:0]     seed,
    input  logic             step,
    output logic [OUT_W-1:0] q
);

    logic [W-1:0] state;
    logic [W-1:0] nxt;

    assign nxt = (state >> 1) ^ (state[0] ? POLY : '0);
    assign q   = state[OUT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RST_VAL;
        end else if (load) begin
            state <= seed;
        end else if (step) begin
            state <= nxt;
        end
    end

endmodule

// File: rtl/gen_fifo_stim.sv
// FIFO write-port stimulus generator: patterned words under a valid/full handshake with a rate throttle.
// First write two cycles after start_i; full_flag holds the pending word and data_o until the FIFO has room.
module gen_fifo_stim #(
    parameter int unsigned DATA_WIDTH = gen_fifo_defines_pkg::DEF_DATA_WIDTH,
    parameter int unsigned CNT_W      = 16,
    parameter logic [31:0] DEF_SEED   = gen_fifo_defines_pkg::DEF_SEED
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic [1:0]            mode_i,
    input  logic [7:0]            rate_i,
    input  logic [CNT_W-1:0]      num_words_i,
    input  logic [31:0]           seed_i,
    input  logic                  full_flag,
    output logic                  write_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_W-1:0]      count_o
);
    import gen_fifo_defines_pkg::*;

    gen_state_e            state_q;
    gen_state_e            state_d;
    gen_mode_e             mode_q;
    logic [7:0]            rate_q;
    logic [CNT_W-1:0]      num_q;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_nxt;
    logic [DATA_WIDTH-1:0] const_q;
    logic [DATA_WIDTH-1:0] incr_q;
    logic [DATA_WIDTH-1:0] walk_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] lfsr_word;
    logic [DATA_WIDTH-1:0] cur_word;
    logic [7:0]            thr_byte;
    logic [31:0]           seed_load;
    logic                  valid_q;
    logic                  valid_d;
    logic                  start_ok;
    logic                  accept;
    logic                  last_acc;
    logic                  owed;
    logic                  thr_pass;
    logic                  load_word;

    assign start_ok  = (state_q == IDLE) && start_i && !stop_i;
    assign accept    = valid_q && !full_flag;
    assign count_nxt = count_q + CNT_W'(accept);
    assign last_acc  = accept && (num_q != '0) && (count_nxt == num_q);
    assign owed      = (num_q == '0) || (count_nxt != num_q);
    assign thr_pass  = (rate_q == 8'hFF) || (thr_byte < rate_q);
    assign seed_load = (seed_i == 32'd0) ? DEF_SEED : seed_i;

    // Generators hold the next word to present and advance whenever a word is moved into data_q.
    assign load_word = valid_d && (!valid_q || accept);

    gen_fifo_lfsr #(
        .W      (32),
        .POLY   (LFSR32_POLY),
        .RST_VAL(DEF_SEED),
        .OUT_W  (DATA_WIDTH)
    ) u_data_lfsr (
        .clk (clk),
        .rst (rst),
        .load(start_ok),
        .seed(seed_load),
        .step(load_word),
        .q   (lfsr_word)
    );

    gen_fifo_lfsr #(
        .W      (16),
        .POLY   (LFSR16_POLY),
        .RST_VAL(THR_SEED),
        .OUT_W  (8)
    ) u_thr_lfsr (
        .clk (clk),
        .rst (rst),
        .load(1'b0),
        .seed(16'h0000),
        .step(state_q == RUN),
        .q   (thr_byte)
    );

    always_comb begin
        cur_word = const_q;
        unique case (mode_q)
            INCR:    cur_word = incr_q;
            LFSR:    cur_word = lfsr_word;
            WALK1:   cur_word = walk_q;
            default: cur_word = const_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_ok) state_d = RUN;
            end
            RUN: begin
                if (stop_i) begin
                    state_d = IDLE;
                end else if (last_acc) begin
                    state_d = DONE;
                end else if (valid_q && !accept) begin
                    valid_d = 1'b1;
                end else begin
                    valid_d = thr_pass && owed;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= INCR;
            rate_q  <= '0;
            num_q   <= '0;
            count_q <= '0;
            const_q <= '0;
            incr_q  <= '0;
            walk_q  <= DATA_WIDTH'(1);
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            if (!valid_d) begin
                data_q <= '0;
            end else if (load_word) begin
                data_q <= cur_word;
            end
            if (start_ok) begin
                mode_q  <= gen_mode_e'(mode_i);
                rate_q  <= rate_i;
                num_q   <= num_words_i;
                const_q <= seed_i[DATA_WIDTH-1:0];
                incr_q  <= seed_i[DATA_WIDTH-1:0];
                walk_q  <= DATA_WIDTH'(1);
                count_q <= '0;
            end else begin
                count_q <= count_nxt;
                if (load_word) begin
                    incr_q <= incr_q + DATA_WIDTH'(1);
                    walk_q <= (walk_q << 1) | (walk_q >> (DATA_WIDTH - 1));
                end
            end
        end
    end

    assign write_o = accept;
    assign data_o  = data_q;
    assign busy_o  = (state_q != IDLE);
    assign done_o  = (state_q == DONE);
    assign count_o = count_q;

endmodule

// File: tb/tb_gen_fifo_stim.sv
// Bench for gen_fifo_stim: directed scenarios plus randomized bursts against a closed-form word model.
module tb_gen_fifo_stim;

    localparam int          DW          = 8;
    localparam int          CW          = 16;
    localparam logic [31:0] TB_DEF_SEED = 32'hACE1_2024;
    localparam logic [31:0] TB_POLY     = 32'h8020_0003;

    logic          clk;
    logic          rst;
    logic          start_i;
    logic          stop_i;
    logic [1:0]    mode_i;
    logic [7:0]    rate_i;
    logic [CW-1:0] num_words_i;
    logic [31:0]   seed_i;
    logic          full_flag;
    logic          write_o;
    logic [DW-1:0] data_o;
    logic          busy_o;
    logic          done_o;
    logic [CW-1:0] count_o;

    int            errors;
    int            checks;
    logic [7:0]    got_q[$];
    bit            got_done;

    gen_fifo_stim #(
        .DATA_WIDTH(DW),
        .CNT_W     (CW),
        .DEF_SEED  (TB_DEF_SEED)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .stop_i     (stop_i),
        .mode_i     (mode_i),
        .rate_i     (rate_i),
        .num_words_i(num_words_i),
        .seed_i     (seed_i),
        .full_flag  (full_flag),
        .write_o    (write_o),
        .data_o     (data_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .count_o    (count_o)
    );

    always #5 clk = ~clk;

    // Inputs change 1 ns after the rising edge; outputs are observed on the falling edge.
    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic to_obs();
        @(negedge clk);
    endtask

    // Word k of a burst, straight from the pattern definitions.
    function automatic logic [7:0] exp_word(input logic [1:0] m, input logic [31:0] s, input int k);
        logic [31:0] l;
        logic [7:0]  r;
        l = (s == 32'd0) ? TB_DEF_SEED : s;
        case (m)
            2'd0:    r = s[7:0] + 8'(k);
            2'd1: begin
                for (int i = 0; i < k; i++) l = (l >> 1) ^ (l[0] ? TB_POLY : 32'd0);
                r = l[7:0];
            end
            2'd2:    r = 8'(1 << (k % DW));
            default: r = s[7:0];
        endcase
        return r;
    endfunction

    // Pulse start_i, then scramble the config inputs so only latched values can matter.
    task automatic begin_burst(input logic [1:0] m, input logic [7:0] r, input logic [15:0] n,
                               input logic [31:0] s);
        mode_i      = m;
        rate_i      = r;
        num_words_i = n;
        seed_i      = s;
        start_i     = 1'b1;
        to_drive();
        start_i     = 1'b0;
        mode_i      = 2'($urandom);
        rate_i      = 8'($urandom);
        num_words_i = 16'($urandom);
        seed_i      = $urandom;
    endtask

    task automatic run_burst(input logic [1:0] m, input logic [7:0] r, input logic [15:0] n,
                             input logic [31:0] s, input int pct, input int budget);
        got_q.delete();
        got_done = 1'b0;
        begin_burst(m, r, n, s);
        for (int c = 0; c < budget && !got_done; c++) begin
            full_flag = (int'($urandom_range(99)) < pct);
            to_obs();
            if (write_o === 1'b1) got_q.push_back(data_o);
            if (done_o === 1'b1) got_done = 1'b1;
            to_drive();
        end
        full_flag = 1'b0;
        if (!got_done) begin
            stop_i = 1'b1;
            to_drive();
            stop_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) to_drive();
        rst = 1'b0;
        to_obs();
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL por_busy: got %0b want 0", busy_o); end
        checks++; if (write_o !== 1'b0) begin errors++; $display("FAIL por_write: got %0b want 0", write_o); end
        checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL por_data: got %0h want 0", data_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL por_done: got %0b want 0", done_o); end
        checks++; if (count_o !== 16'd0) begin errors++; $display("FAIL por_count: got %0d want 0", count_o); end
        to_drive();
        begin_burst(2'd0, 8'hFF, 16'd0, 32'h33);
        repeat (5) to_drive();
        to_obs();
        checks++; if (count_o !== 16'd4) begin errors++; $display("FAIL midburst_count: got %0d want 4", count_o); end
        to_drive();
        rst = 1'b1;
        repeat (3) to_drive();
        rst = 1'b0;
        to_obs();
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b want 0", busy_o); end
        checks++; if (write_o !== 1'b0) begin errors++; $display("FAIL rst_write: got %0b want 0", write_o); end
        checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL rst_data: got %0h want 0", data_o); end
        checks++; if (count_o !== 16'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", count_o); end
        to_drive();
    endtask

    task automatic test_incr_burst();
        logic [7:0]  exp_d [7];
        logic        exp_w [7];
        logic        exp_dn[7];
        logic        exp_b [7];
        logic [15:0] exp_c [7];
        exp_d  = '{8'h00, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h00};
        exp_w  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_dn = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_b  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_c  = '{16'd0, 16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd4};
        full_flag = 1'b0;
        begin_burst(2'd0, 8'hFF, 16'd4, 32'h0000_00FE);
        for (int i = 0; i < 7; i++) begin
            to_obs();
            checks++; if (write_o !== exp_w[i]) begin errors++; $display("FAIL incr_write[%0d]: got %0b want %0b", i, write_o, exp_w[i]); end
            checks++; if (data_o !== exp_d[i]) begin errors++; $display("FAIL incr_data[%0d]: got %0h want %0h", i, data_o, exp_d[i]); end
            checks++; if (done_o !== exp_dn[i]) begin errors++; $display("FAIL incr_done[%0d]: got %0b want %0b", i, done_o, exp_dn[i]); end
            checks++; if (busy_o !== exp_b[i]) begin errors++; $display("FAIL incr_busy[%0d]: got %0b want %0b", i, busy_o, exp_b[i]); end
            checks++; if (count_o !== exp_c[i]) begin errors++; $display("FAIL incr_count[%0d]: got %0d want %0d", i, count_o, exp_c[i]); end
            to_drive();
        end
    endtask

    task automatic test_full_hold();
        int         acc = 0;
        bit         fin = 1'b0;
        logic [7:0] e;
        begin_burst(2'd1, 8'hFF, 16'd10, 32'd1);
        for (int c = 0; c < 40 && !fin; c++) begin
            full_flag = (c >= 3 && c <= 7);
            to_obs();
            e = exp_word(2'd1, 32'd1, acc);
            if (full_flag) begin
                checks++; if (write_o !== 1'b0) begin errors++; $display("FAIL hold_write[c%0d]: got %0b want 0", c, write_o); end
                checks++; if (data_o !== e) begin errors++; $display("FAIL hold_data[c%0d]: got %0h want %0h", c, data_o, e); end
            end else if (c >= 1 && acc < 10) begin
                checks++; if (write_o !== 1'b1) begin errors++; $display("FAIL lfsr_write[c%0d]: got %0b want 1", c, write_o); end
                checks++; if (data_o !== e) begin errors++; $display("FAIL lfsr_data[w%0d]: got %0h want %0h", acc, data_o, e); end
                if (write_o === 1'b1) acc++;
            end
            if (done_o === 1'b1) fin = 1'b1;
            to_drive();
        end
        full_flag = 1'b0;
        checks++; if (!fin) begin errors++; $display("FAIL lfsr_done: got 0 want 1 within 40 cycles"); end
        checks++; if (acc != 10) begin errors++; $display("FAIL lfsr_words: got %0d want 10", acc); end
        checks++; if (count_o !== 16'd10) begin errors++; $display("FAIL lfsr_count: got %0d want 10", count_o); end
    endtask

    task automatic test_throttle();
        int pulses = 0;
        int bad    = 0;
        full_flag = 1'b0;
        begin_burst(2'd0, 8'h40, 16'd0, 32'd0);
        for (int c = 0; c < 10000; c++) begin
            to_obs();
            if (write_o === 1'b1) begin
                if (data_o !== 8'(pulses)) bad++;
                pulses++;
            end
            to_drive();
        end
        stop_i = 1'b1;
        to_obs();
        if (write_o === 1'b1) pulses++;
        to_drive();
        stop_i = 1'b0;
        to_obs();
        checks++; if (pulses < 2300 || pulses > 2700) begin errors++; $display("FAIL thr_rate: got %0d writes want 2300..2700 of 10000", pulses); end
        checks++; if (count_o !== 16'(pulses)) begin errors++; $display("FAIL thr_count: got %0d want %0d", count_o, pulses); end
        checks++; if (bad != 0) begin errors++; $display("FAIL thr_seq: got %0d bad words want 0", bad); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL thr_stop_busy: got %0b want 0", busy_o); end
        to_drive();
    endtask

    task automatic test_stop();
        int acc = 0;
        int bad = 0;
        begin_burst(2'd0, 8'hFF, 16'd8, 32'h10);
        for (int c = 0; c < 5; c++) begin
            full_flag = (acc >= 2);
            to_obs();
            if (write_o === 1'b1) acc++;
            if (c == 4) begin
                checks++; if (write_o !== 1'b0) begin errors++; $display("FAIL stop_blocked_write: got %0b want 0", write_o); end
                checks++; if (data_o !== 8'h12) begin errors++; $display("FAIL stop_pending_data: got %0h want 12", data_o); end
            end
            to_drive();
        end
        checks++; if (acc != 2) begin errors++; $display("FAIL stop_accepted: got %0d want 2", acc); end
        stop_i = 1'b1;
        to_obs();
        to_drive();
        stop_i    = 1'b0;
        full_flag = 1'b0;
        to_obs();
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL stop_busy: got %0b want 0", busy_o); end
        checks++; if (write_o !== 1'b0) begin errors++; $display("FAIL stop_write: got %0b want 0", write_o); end
        checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL stop_data: got %0h want 0", data_o); end
        checks++; if (count_o !== 16'd2) begin errors++; $display("FAIL stop_count: got %0d want 2", count_o); end
        for (int c = 0; c < 3; c++) begin
            to_drive();
            to_obs();
            if (done_o !== 1'b0 || write_o !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL stop_quiet: got %0d active cycles want 0", bad); end
        to_drive();
        mode_i      = 2'd0;
        rate_i      = 8'hFF;
        num_words_i = 16'd3;
        start_i     = 1'b1;
        stop_i      = 1'b1;
        to_drive();
        start_i = 1'b0;
        stop_i  = 1'b0;
        bad     = 0;
        for (int c = 0; c < 3; c++) begin
            to_obs();
            if (busy_o !== 1'b0 || write_o !== 1'b0) bad++;
            to_drive();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL start_stop_idle: got %0d busy cycles want 0", bad); end
    endtask

    task automatic test_walk_and_seed();
        logic [7:0] e;
        run_burst(2'd2, 8'hFF, 16'd10, 32'd0, 0, 100);
        checks++; if (!got_done) begin errors++; $display("FAIL walk_done: got 0 want 1"); end
        checks++; if (got_q.size() != 10) begin errors++; $display("FAIL walk_len: got %0d want 10", got_q.size()); end
        for (int k = 0; k < got_q.size() && k < 10; k++) begin
            e = exp_word(2'd2, 32'd0, k);
            checks++; if (got_q[k] !== e) begin errors++; $display("FAIL walk_data[%0d]: got %0h want %0h", k, got_q[k], e); end
        end
        run_burst(2'd1, 8'hFF, 16'd6, 32'd0, 0, 100);
        checks++; if (got_q.size() != 6) begin errors++; $display("FAIL defseed_len: got %0d want 6", got_q.size()); end
        if (got_q.size() > 0) begin
            checks++; if (got_q[0] !== 8'h24) begin errors++; $display("FAIL defseed_first: got %0h want 24", got_q[0]); end
        end
        for (int k = 0; k < got_q.size() && k < 6; k++) begin
            e = exp_word(2'd1, 32'd0, k);
            checks++; if (got_q[k] !== e) begin errors++; $display("FAIL defseed_data[%0d]: got %0h want %0h", k, got_q[k], e); end
        end
    endtask

    task automatic test_random();
        logic [1:0]  m;
        logic [7:0]  r;
        logic [15:0] n;
        logic [31:0] s;
        int          pct;
        int          bad;
        for (int b = 0; b < 8; b++) begin
            m   = 2'($urandom_range(3));
            s   = ($urandom_range(3) == 0) ? 32'd0 : $urandom;
            r   = ($urandom_range(1) == 1) ? 8'hFF : 8'($urandom_range(255, 32));
            n   = 16'($urandom_range(20, 1));
            pct = int'($urandom_range(60));
            run_burst(m, r, n, s, pct, 3000);
            bad = 0;
            for (int k = 0; k < got_q.size() && k < int'(n); k++) begin
                if (got_q[k] !== exp_word(m, s, k)) bad++;
            end
            checks++; if (!got_done) begin errors++; $display("FAIL rnd%0d_done: got 0 want 1 (mode %0d rate %0h)", b, m, r); end
            checks++; if (got_q.size() != int'(n)) begin errors++; $display("FAIL rnd%0d_len: got %0d want %0d", b, got_q.size(), n); end
            checks++; if (bad != 0) begin errors++; $display("FAIL rnd%0d_data: got %0d wrong words want 0 (mode %0d seed %0h)", b, bad, m, s); end
            checks++; if (count_o !== n) begin errors++; $display("FAIL rnd%0d_count: got %0d want %0d", b, count_o, n); end
        end
    endtask

    initial begin
        clk         = 1'b0;
        rst         = 1'b1;
        start_i     = 1'b0;
        stop_i      = 1'b0;
        mode_i      = 2'd0;
        rate_i      = 8'd0;
        num_words_i = 16'd0;
        seed_i      = 32'd0;
        full_flag   = 1'b0;
        errors      = 0;
        checks      = 0;
        test_reset();
        test_incr_burst();
        test_full_hold();
        test_throttle();
        test_stop();
        test_walk_and_seed();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at 2 ms, want completion");
        $fatal(1, "timeout");
    end

endmodule
